// File: rtl/frv_mem_arbiter_if.sv
// rtl/frv_mem_arbiter_if.sv - req/gnt/recv/ack memory port bundle
// The master side issues requests and accepts responses; the slave side grants and responds.
interface frv_mem_arbiter_if;
    logic        req;
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        gnt;
    logic        recv;
    logic        ack;
    logic        error;
    logic [31:0] rdata;

    modport master (
        output req, wen, strb, wdata, addr, ack,
        input  gnt, recv, error, rdata
    );

    modport slave (
        input  req, wen, strb, wdata, addr, ack,
        output gnt, recv, error, rdata
    );
endinterface

// File: rtl/frv_mem_arbiter.sv
// rtl/frv_mem_arbiter.sv - fetch/load-store arbiter onto one in-order memory port
// Grants one requester per transaction, records owners in order and steers responses back.
module frv_mem_arbiter #(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    frv_mem_arbiter_if.slave      i_bus,
    frv_mem_arbiter_if.slave      d_bus,
    frv_mem_arbiter_if.master     m_bus,
    output logic                  rsp_orphan
);

    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_hold_d;
    logic [OUTSTANDING-1:0] r_owner_d;
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [CW-1:0]          r_count;
    logic [SW-1:0]          r_starve;
    logic                   r_orphan;

    logic w_full;
    logic w_empty;
    logic w_starved;
    logic w_sel_d;
    logic w_m_req;
    logic w_push;
    logic w_pop;
    logic w_head_d;
    logic w_m_ack;
    logic w_i_gnt;
    logic w_d_gnt;

    assign w_full    = (r_count == CW'(OUTSTANDING));
    assign w_empty   = (r_count == '0);
    assign w_starved = (r_starve == SW'(STARVE_LIMIT));
    assign w_head_d  = r_owner_d[r_rptr];

    // A held request keeps its owner even if the other requester becomes preferred.
    always_comb begin
        w_next_state = r_state;
        w_sel_d      = 1'b0;
        w_m_req      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_sel_d = d_bus.req && !(i_bus.req && w_starved);
                w_m_req = (i_bus.req || d_bus.req) && !w_full;
                if (w_m_req && !m_bus.gnt) begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_sel_d = r_hold_d;
                w_m_req = 1'b1;
                if (m_bus.gnt) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_i_gnt = m_bus.gnt && w_m_req && !w_sel_d;
    assign w_d_gnt = m_bus.gnt && w_m_req && w_sel_d;
    assign w_push  = w_m_req && m_bus.gnt;
    assign w_m_ack = w_empty ? 1'b1 : (w_head_d ? d_bus.ack : i_bus.ack);
    assign w_pop   = m_bus.recv && w_m_ack && !w_empty;

    assign m_bus.req   = w_m_req;
    assign m_bus.wen   = w_sel_d ? d_bus.wen   : i_bus.wen;
    assign m_bus.strb  = w_sel_d ? d_bus.strb  : i_bus.strb;
    assign m_bus.wdata = w_sel_d ? d_bus.wdata : i_bus.wdata;
    assign m_bus.addr  = w_sel_d ? d_bus.addr  : i_bus.addr;
    assign m_bus.ack   = w_m_ack;

    assign i_bus.gnt   = w_i_gnt;
    assign d_bus.gnt   = w_d_gnt;
    assign i_bus.recv  = m_bus.recv && !w_empty && !w_head_d;
    assign d_bus.recv  = m_bus.recv && !w_empty && w_head_d;
    assign i_bus.rdata = m_bus.rdata;
    assign d_bus.rdata = m_bus.rdata;
    assign i_bus.error = m_bus.error;
    assign d_bus.error = m_bus.error;

    assign rsp_orphan  = r_orphan;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state  <= ST_IDLE;
            r_hold_d <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE) begin
                r_hold_d <= w_sel_d;
            end
        end
    end

    // Owner FIFO: one bit per outstanding request, 1 = load/store side.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_owner_d <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_owner_d[r_wptr] <= w_sel_d;
                r_wptr <= (r_wptr == PW'(OUTSTANDING - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PW'(OUTSTANDING - 1)) ? '0 : r_rptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_starve <= '0;
        end else if (!i_bus.req || w_i_gnt) begin
            r_starve <= '0;
        end else if (w_d_gnt && !w_starved) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_orphan <= 1'b0;
        end else if (m_bus.recv && w_empty) begin
            r_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// tb/tb_frv_mem_arbiter.sv - vector table, corner sequences and random run against a queue model
module tb_frv_mem_arbiter;

    localparam int OUTSTANDING  = 2;
    localparam int STARVE_LIMIT = 4;

    logic g_clk = 1'b0;
    logic g_resetn;
    logic rsp_orphan;

    frv_mem_arbiter_if i_if ();
    frv_mem_arbiter_if d_if ();
    frv_mem_arbiter_if m_if ();

    frv_mem_arbiter #(
        .OUTSTANDING (OUTSTANDING),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .i_bus     (i_if),
        .d_bus     (d_if),
        .m_bus     (m_if),
        .rsp_orphan(rsp_orphan)
    );

    always #5 g_clk = ~g_clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owners in arrival order, a pending-offer flag, a starvation tally.
    bit oq[$];
    bit held, held_d, orphan_m;
    int starve;
    bit e_sel_d, e_mreq, e_ig, e_dg, e_ir, e_dr, e_mack;

    task automatic model_reset();
        oq.delete();
        held = 0; held_d = 0; orphan_m = 0; starve = 0;
    endtask

    task automatic model_eval();
        bit empty;
        empty = (oq.size() == 0);
        if (held) begin
            e_sel_d = held_d;
            e_mreq  = 1;
        end else begin
            e_sel_d = d_if.req && !(i_if.req && starve == STARVE_LIMIT);
            e_mreq  = (i_if.req || d_if.req) && (oq.size() < OUTSTANDING);
        end
        e_ig   = m_if.gnt && e_mreq && !e_sel_d;
        e_dg   = m_if.gnt && e_mreq && e_sel_d;
        e_mack = empty ? 1'b1 : (oq[0] ? d_if.ack : i_if.ack);
        e_ir   = m_if.recv && !empty && !oq[0];
        e_dr   = m_if.recv && !empty && oq[0];
    endtask

    task automatic model_advance();
        model_eval();
        if (m_if.recv && e_mack) begin
            if (oq.size() == 0) orphan_m = 1;
            else oq.delete(0);
        end
        if (e_mreq && m_if.gnt) begin
            oq.push_back(e_sel_d);
            held = 0;
        end else if (e_mreq) begin
            held   = 1;
            held_d = e_sel_d;
        end
        if (!i_if.req || e_ig) starve = 0;
        else if (e_dg && starve < STARVE_LIMIT) starve++;
    endtask

    task automatic check_vs_model();
        model_eval();
        chk1("i_gnt", i_if.gnt, e_ig);
        chk1("d_gnt", d_if.gnt, e_dg);
        chk1("m_req", m_if.req, e_mreq);
        chk1("i_recv", i_if.recv, e_ir);
        chk1("d_recv", d_if.recv, e_dr);
        chk1("m_ack", m_if.ack, e_mack);
        chk1("rsp_orphan", rsp_orphan, orphan_m);
        if (e_mreq) begin
            chk32("m_addr", m_if.addr, e_sel_d ? d_if.addr : i_if.addr);
            chk32("m_wdata", m_if.wdata, e_sel_d ? d_if.wdata : i_if.wdata);
            chk32("m_ctl", {27'd0, m_if.wen, m_if.strb},
                  e_sel_d ? {27'd0, d_if.wen, d_if.strb} : {27'd0, i_if.wen, i_if.strb});
        end
        if (e_ir) chk32("i_rdata", i_if.rdata, m_if.rdata);
        if (e_dr) chk1("d_error", d_if.error, m_if.error);
    endtask

    task automatic clear_inputs();
        i_if.req = 0; i_if.wen = 0; i_if.strb = 0; i_if.wdata = 0; i_if.addr = 32'h1000; i_if.ack = 1;
        d_if.req = 0; d_if.wen = 0; d_if.strb = 0; d_if.wdata = 0; d_if.addr = 32'h2000; d_if.ack = 1;
        m_if.gnt = 0; m_if.recv = 0; m_if.error = 0; m_if.rdata = 0;
    endtask

    task automatic do_reset();
        g_resetn = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge g_clk);
        g_resetn = 1;
    endtask

    // {iq, dq, m_gnt, m_recv, i_ack, d_ack} -> {i_gnt, d_gnt, m_req, i_recv, d_recv, m_ack}
    typedef struct packed {
        logic [5:0] stim;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[14];
    bit   ig_last, dg_last;

    initial begin
        tbl[0]  = {6'b101011, 6'b101001};
        tbl[1]  = {6'b101111, 6'b101101};
        tbl[2]  = {6'b000111, 6'b000101};
        tbl[3]  = {6'b111011, 6'b011001};
        tbl[4]  = {6'b111011, 6'b011001};
        tbl[5]  = {6'b111110, 6'b000010};
        tbl[6]  = {6'b111111, 6'b000011};
        tbl[7]  = {6'b111011, 6'b011001};
        tbl[8]  = {6'b111111, 6'b000011};
        tbl[9]  = {6'b111111, 6'b011011};
        tbl[10] = {6'b111011, 6'b101001};
        tbl[11] = {6'b000111, 6'b000011};
        tbl[12] = {6'b000100, 6'b000100};
        tbl[13] = {6'b000111, 6'b000101};

        g_resetn = 0;
        clear_inputs();
        #1;
        chk1("rst_i_gnt", i_if.gnt, 1'b0);
        chk1("rst_d_gnt", d_if.gnt, 1'b0);
        chk1("rst_m_req", m_if.req, 1'b0);
        chk1("rst_m_ack", m_if.ack, 1'b1);
        chk1("rst_orphan", rsp_orphan, 1'b0);
        do_reset();

        for (int r = 0; r < 14; r++) begin
            {i_if.req, d_if.req, m_if.gnt, m_if.recv, i_if.ack, d_if.ack} = tbl[r].stim;
            m_if.rdata = 32'hA0 + 32'(r);
            #1;
            chk1($sformatf("tbl%0d_i_gnt", r), i_if.gnt, tbl[r].exp[5]);
            chk1($sformatf("tbl%0d_d_gnt", r), d_if.gnt, tbl[r].exp[4]);
            chk1($sformatf("tbl%0d_m_req", r), m_if.req, tbl[r].exp[3]);
            chk1($sformatf("tbl%0d_i_recv", r), i_if.recv, tbl[r].exp[2]);
            chk1($sformatf("tbl%0d_d_recv", r), d_if.recv, tbl[r].exp[1]);
            chk1($sformatf("tbl%0d_m_ack", r), m_if.ack, tbl[r].exp[0]);
            if (tbl[r].exp[5]) chk32($sformatf("tbl%0d_addr", r), m_if.addr, 32'h1000);
            if (tbl[r].exp[4]) chk32($sformatf("tbl%0d_addr", r), m_if.addr, 32'h2000);
            if (tbl[r].exp[2]) chk32($sformatf("tbl%0d_i_rdata", r), i_if.rdata, 32'hA0 + 32'(r));
            @(negedge g_clk);
        end

        // Held data request is not displaced by a fetch arriving while it waits.
        do_reset();
        d_if.req = 1;
        #1; chk1("hold_m_req", m_if.req, 1'b1); chk32("hold_addr0", m_if.addr, 32'h2000);
        @(negedge g_clk); i_if.req = 1;
        #1; chk32("hold_addr1", m_if.addr, 32'h2000); chk1("hold_no_gnt", d_if.gnt, 1'b0);
        @(negedge g_clk);
        #1; chk32("hold_addr2", m_if.addr, 32'h2000);
        @(negedge g_clk); m_if.gnt = 1;
        #1; chk1("hold_d_gnt", d_if.gnt, 1'b1); chk1("hold_i_gnt", i_if.gnt, 1'b0);
        @(negedge g_clk); d_if.req = 0;
        #1; chk32("hold_then_i", m_if.addr, 32'h1000); chk1("hold_then_i_gnt", i_if.gnt, 1'b1);

        // Held fetch keeps the port even though a fresh data request would win in IDLE.
        do_reset();
        i_if.req = 1;
        @(negedge g_clk); d_if.req = 1;
        #1; chk32("ihold_addr", m_if.addr, 32'h1000);
        @(negedge g_clk); m_if.gnt = 1;
        #1; chk1("ihold_i_gnt", i_if.gnt, 1'b1); chk1("ihold_d_gnt", d_if.gnt, 1'b0);

        // Response with nothing outstanding is swallowed and flagged until reset.
        do_reset();
        m_if.recv = 1;
        #1;
        chk1("orph_m_ack", m_if.ack, 1'b1);
        chk1("orph_i_recv", i_if.recv, 1'b0);
        chk1("orph_d_recv", d_if.recv, 1'b0);
        @(negedge g_clk); m_if.recv = 0;
        #1; chk1("orph_set", rsp_orphan, 1'b1);
        @(negedge g_clk);
        #1; chk1("orph_sticky", rsp_orphan, 1'b1);
        #2; g_resetn = 0;
        #1; chk1("orph_async_clr", rsp_orphan, 1'b0);

        do_reset();
        ig_last = 0; dg_last = 0;
        for (int c = 0; c < 4000; c++) begin
            if (ig_last || !i_if.req) begin
                i_if.req   = ($urandom_range(0, 99) < 60);
                i_if.addr  = $urandom;
                i_if.wdata = $urandom;
                i_if.wen   = 1'($urandom_range(0, 1));
                i_if.strb  = 4'($urandom_range(0, 15));
            end
            if (dg_last || !d_if.req) begin
                d_if.req   = ($urandom_range(0, 99) < 60);
                d_if.addr  = $urandom;
                d_if.wdata = $urandom;
                d_if.wen   = 1'($urandom_range(0, 1));
                d_if.strb  = 4'($urandom_range(0, 15));
            end
            m_if.gnt   = ($urandom_range(0, 99) < 60);
            m_if.recv  = (oq.size() != 0) && ($urandom_range(0, 1) == 1);
            m_if.rdata = $urandom;
            m_if.error = 1'($urandom_range(0, 1));
            i_if.ack   = ($urandom_range(0, 99) < 70);
            d_if.ack   = ($urandom_range(0, 99) < 70);
            #1;
            check_vs_model();
            ig_last = e_ig;
            dg_last = e_dg;
            model_advance();
            @(negedge g_clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
